// File: rtl/path_streamer.sv
// path_streamer: snapshots the maze solver's visited-cell bitmap when the
// solver reports done. It then scans the snapshot in row-major order and
// streams the (x,y) coordinates of every visited cell over a valid/ready
// interface. finished is raised once the whole bitmap has been scanned.
//
// Optional feature macro: PATH_LEN_EN
//   When it is defined, the block adds output path_len. This counter holds
//   the number of cells accepted by the consumer since the last capture.
//
// Handshake (out_valid/out_ready):
//   - A cell transfers on a rising clk edge where out_valid && out_ready.
//   - Once out_valid is raised, out_valid/out_x/out_y stay stable until that
//     transfer happens.
//   - out_ready sampled while out_valid is low has no effect.
//   - rst drops any pending cell without a transfer.
//
// dbg_state exposes the FSM encoding: IDLE=0, SCAN=1, EMIT=2, DONE=3.
module path_streamer #(
    parameter int SIZE = 9,
    parameter int N    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] path [SIZE],
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_x,
    output logic [N-1:0]    out_y,
    output logic            busy,
    output logic            finished,
`ifdef PATH_LEN_EN
    output logic [2*N:0]    path_len,
`endif
    output logic [1:0]      dbg_state
);

    // The coordinate counters must be able to hold SIZE-1.
    generate
        if (SIZE - 1 >= (1 << N)) begin : g_bad_params
            $error("path_streamer: SIZE-1 does not fit in N coordinate bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [N-1:0] LAST = N'(SIZE - 1);

    state_t          r_state;
    logic [N-1:0]    r_cx;
    logic [N-1:0]    r_cy;
    logic            r_valid;
    logic [N-1:0]    r_x;
    logic [N-1:0]    r_y;
    logic            r_busy;
    logic            r_finished;
    logic [SIZE-1:0] r_snap [SIZE];

    state_t          w_state_n;
    logic [N-1:0]    w_cx_n;
    logic [N-1:0]    w_cy_n;
    logic            w_valid_n;
    logic [N-1:0]    w_x_n;
    logic [N-1:0]    w_y_n;
    logic            w_capture;
    logic            w_accept;
    logic            w_last;
    logic [N-1:0]    w_cx_adv;
    logic [N-1:0]    w_cy_adv;

    // Row-major step to the next cell. The counters stop at the last cell;
    // they are never advanced past it.
    assign w_last   = (r_cx == LAST) && (r_cy == LAST);
    assign w_cx_adv = (r_cx == LAST) ? '0 : r_cx + N'(1);
    assign w_cy_adv = (r_cx == LAST) ? r_cy + N'(1) : r_cy;

    // Next-state and next-output logic. Defaults hold every register.
    always_comb begin
        w_state_n = r_state;
        w_cx_n    = r_cx;
        w_cy_n    = r_cy;
        w_valid_n = r_valid;
        w_x_n     = r_x;
        w_y_n     = r_y;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_capture = 1'b1;
                    w_cx_n    = '0;
                    w_cy_n    = '0;
                    w_state_n = SCAN;
                end
            end
            SCAN: begin
                if (r_snap[r_cy][r_cx]) begin
                    // Present this cell. The counters stay on it until it
                    // has been accepted.
                    w_x_n     = r_cx;
                    w_y_n     = r_cy;
                    w_valid_n = 1'b1;
                    w_state_n = EMIT;
                end else if (w_last) begin
                    w_state_n = DONE;
                end else begin
                    w_cx_n = w_cx_adv;
                    w_cy_n = w_cy_adv;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    w_accept  = 1'b1;
                    w_valid_n = 1'b0;
                    if (w_last) begin
                        w_state_n = DONE;
                    end else begin
                        w_cx_n    = w_cx_adv;
                        w_cy_n    = w_cy_adv;
                        w_state_n = SCAN;
                    end
                end
            end
            DONE: begin
                // Wait for the solver to drop done before re-arming, so a
                // level-high start does not retrigger a scan.
                if (!start) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // State, counters, output registers and snapshot. rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cx       <= '0;
            r_cy       <= '0;
            r_valid    <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_snap     <= '{default: '0};
        end else begin
            r_state    <= w_state_n;
            r_cx       <= w_cx_n;
            r_cy       <= w_cy_n;
            r_valid    <= w_valid_n;
            r_x        <= w_x_n;
            r_y        <= w_y_n;
            r_busy     <= (w_state_n == SCAN) || (w_state_n == EMIT);
            r_finished <= (w_state_n == DONE);
            if (w_capture) begin
                r_snap <= path;
            end
        end
    end

`ifdef PATH_LEN_EN
    logic [2*N:0] r_path_len;

    // Count accepted transfers since the last capture.
    always_ff @(posedge clk) begin
        if (rst || w_capture) begin
            r_path_len <= '0;
        end else if (w_accept) begin
            r_path_len <= r_path_len + (2*N+1)'(1);
        end
    end

    assign path_len = r_path_len;
`endif

    assign out_valid = r_valid;
    assign out_x     = r_x;
    assign out_y     = r_y;
    assign busy      = r_busy;
    assign finished  = r_finished;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_path_streamer.sv
// Directed bench for path_streamer (SIZE=9, N=4).
module tb_path_streamer;

  localparam int SIZE = 9;
  localparam int N    = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic            clk;
  logic            rst;
  logic            start;
  logic [SIZE-1:0] tb_path [SIZE];
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_x;
  logic [N-1:0]    out_y;
  logic            busy;
  logic            finished;
  logic [1:0]      dbg_state;
`ifdef PATH_LEN_EN
  logic [2*N:0]    path_len;
`endif

  int n_total;
  int n_bad;

  // expected cells, encoded {y, x}
  logic [7:0] exp_q[$];

  path_streamer #(.SIZE(SIZE), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .path      (tb_path),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .busy      (busy),
    .finished  (finished),
`ifdef PATH_LEN_EN
    .path_len  (path_len),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic       prev_stall;
  logic       prev_rst;
  logic [7:0] held_cell;

  initial begin
    prev_stall = 1'b0;
    prev_rst   = 1'b1;
    held_cell  = '0;
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_cell", 32'({out_y, out_x}), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("cell_order", 32'({out_y, out_x}), 32'(e));
      end
    end
    if (prev_stall && !prev_rst) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_xy", 32'({out_y, out_x}), 32'(held_cell));
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_rst   = rst;
    held_cell  = {out_y, out_x};
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_path();
    for (int y = 0; y < SIZE; y++) tb_path[y] = '0;
  endtask

  task automatic set_cell(input int x, input int y);
    tb_path[y][x] = 1'b1;
  endtask

  task automatic load_four();
    clear_path();
    set_cell(0, 0);
    set_cell(1, 0);
    set_cell(1, 1);
    set_cell(8, 8);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      cyc();
      n++;
    end
    check({tag, "_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_finished(input string tag);
    int n;
    n = 0;
    while (!finished && n < 400) begin
      cyc();
      n++;
    end
    check({tag, "_finished"}, 32'(finished), 32'd1);
  endtask

  task automatic accept_one();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    clear_path();
    cyc();
    cyc();

    // reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_x", 32'(out_x), 32'd0);
    check("rst_y", 32'(out_y), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    cyc();

    // empty bitmap: DONE exactly 81 cycles after entering SCAN
    out_ready = 1'b1;
    start     = 1'b1;
    cyc();
    check("empty_busy", 32'(busy), 32'd1);
    cnt = 0;
    while (!finished && cnt < 200) begin
      cyc();
      cnt++;
    end
    check("empty_scan_cycles", 32'(cnt), 32'd81);
    check("empty_state", 32'(dbg_state), 32'(ST_DONE));
    check("empty_busy_done", 32'(busy), 32'd0);
`ifdef PATH_LEN_EN
    check("empty_path_len", 32'(path_len), 32'd0);
`endif
    start = 1'b0;
    cyc();
    check("empty_rearm_fin", 32'(finished), 32'd0);
    check("empty_rearm_state", 32'(dbg_state), 32'(ST_IDLE));

    // four cells, consumer always ready
    load_four();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h88);
    start = 1'b1;
    wait_finished("four");
    check("four_all_sent", 32'(exp_q.size()), 32'd0);
    check("four_last_x", 32'(out_x), 32'd8);
    check("four_last_y", 32'(out_y), 32'd8);
    check("four_valid_done", 32'(out_valid), 32'd0);
`ifdef PATH_LEN_EN
    check("four_path_len", 32'(path_len), 32'd4);
`endif
    start = 1'b0;
    cyc();

    // back-pressure on (1,0) and snapshot isolation
    load_four();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h88);
    out_ready = 1'b0;
    start     = 1'b1;
    cyc();
    cyc();
    cyc();
    for (int y = 0; y < SIZE; y++) tb_path[y] = '1;
    wait_valid("bp_c0");
    check("bp_c0_xy", 32'({out_y, out_x}), 32'h00);
    accept_one();
    wait_valid("bp_c1");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_x", 32'(out_x), 32'd1);
      check("bp_hold_y", 32'(out_y), 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    wait_finished("bp");
    check("bp_all_sent", 32'(exp_q.size()), 32'd0);
`ifdef PATH_LEN_EN
    check("bp_path_len", 32'(path_len), 32'd4);
`endif
    start     = 1'b0;
    out_ready = 1'b0;
    cyc();

    // reset while presenting (1,1), then restart
    load_four();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    start = 1'b1;
    wait_valid("rs_c0");
    accept_one();
    wait_valid("rs_c1");
    accept_one();
    wait_valid("rs_c2");
    check("rs_c2_xy", 32'({out_y, out_x}), 32'h11);
    rst = 1'b1;
    cyc();
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rs_dropped", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h88);
    out_ready = 1'b1;
    wait_finished("rs_restart");
    check("rs_all_sent", 32'(exp_q.size()), 32'd0);

    // DONE -> drop start one cycle -> new path with only (4,2)
    start = 1'b0;
    cyc();
    check("re_fin_low", 32'(finished), 32'd0);
    check("re_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    clear_path();
    set_cell(4, 2);
    exp_q.push_back(8'h24);
    start = 1'b1;
    wait_finished("re");
    check("re_all_sent", 32'(exp_q.size()), 32'd0);
    check("re_last_x", 32'(out_x), 32'd4);
    check("re_last_y", 32'(out_y), 32'd2);
`ifdef PATH_LEN_EN
    check("re_path_len", 32'(path_len), 32'd1);
`endif
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
